// File: rtl/lfsr_prbs_checker_if.sv
// rtl/lfsr_prbs_checker_if.sv - stream, control and status bundle of the PRBS checker
//
// Purpose: groups the received bit stream, control strobes and status outputs
//          of lfsr_prbs_checker so they travel as one port.
// Signals:
//   LOAD_I    master->slave  latch POLY_I and restart synchronisation
//   POLY_I    master->slave  [W] tap mask, bit i set = state bit i feeds the XOR
//   EN_I      master->slave  BIT_I valid this cycle
//   BIT_I     master->slave  received serial bit
//   CLR_I     master->slave  clear the error counter
//   LOCKED_O  slave->master  checker locked to the stream
//   ERR_O     slave->master  one-cycle pulse per mismatching accepted bit
//   ERR_CNT_O slave->master  [ERR_CNT_W] saturating mismatch count
interface lfsr_prbs_checker_if #(
  parameter int W         = 8,
  parameter int ERR_CNT_W = 16
);
  logic                 LOAD_I;
  logic [W-1:0]         POLY_I;
  logic                 EN_I;
  logic                 BIT_I;
  logic                 CLR_I;
  logic                 LOCKED_O;
  logic                 ERR_O;
  logic [ERR_CNT_W-1:0] ERR_CNT_O;

  modport master (
    output LOAD_I, POLY_I, EN_I, BIT_I, CLR_I,
    input  LOCKED_O, ERR_O, ERR_CNT_O
  );

  modport slave (
    input  LOAD_I, POLY_I, EN_I, BIT_I, CLR_I,
    output LOCKED_O, ERR_O, ERR_CNT_O
  );
endinterface

// File: rtl/lfsr_prbs_checker.sv
// rtl/lfsr_prbs_checker.sv - self-synchronising Fibonacci LFSR PRBS checker
//
// Purpose: fills a local LFSR from the received stream, hunts for LOCK_CNT
//          consecutive correct predictions, then free-runs and flags every
//          mismatching bit. Too many errors inside one window drop it back
//          to hunting.
// Ports:
//   CLK_I    in  clock, rising edge
//   RST_N_I  in  asynchronous reset, active low
//   bus      lfsr_prbs_checker_if.slave (LOAD_I, POLY_I, EN_I, BIT_I, CLR_I in;
//            LOCKED_O, ERR_O, ERR_CNT_O out)
module lfsr_prbs_checker #(
  parameter int W         = 8,
  parameter int LOCK_CNT  = 16,
  parameter int LOSS_WIN  = 32,
  parameter int LOSS_THR  = 4,
  parameter int ERR_CNT_W = 16
) (
  input  logic               CLK_I,
  input  logic               RST_N_I,
  lfsr_prbs_checker_if.slave bus
);

  localparam int FILL_W  = (W > 1) ? $clog2(W) : 1;
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int WIN_W   = (LOSS_WIN > 1) ? $clog2(LOSS_WIN) : 1;
  localparam int WERR_W  = $clog2(LOSS_THR + 1);

  // Terminal values are compared before the increment, hence the "-1".
  localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(W - 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
  localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(LOSS_WIN - 1);
  localparam logic [WERR_W-1:0]  WERR_LAST  = WERR_W'(LOSS_THR - 1);

  typedef enum logic [1:0] {
    ST_FILL,
    ST_HUNT,
    ST_LOCKED
  } state_t;

  state_t               fsm;
  logic [W-1:0]         poly_reg;
  logic [W-1:0]         state_reg;
  logic [FILL_W-1:0]    fill_cnt;
  logic [MATCH_W-1:0]   match_cnt;
  logic [WIN_W-1:0]     win_cnt;
  logic [WERR_W-1:0]    win_err;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic                 locked_q;
  logic                 err_q;

  logic pred;
  logic accepted;
  logic mismatch;
  logic err_hit;

  assign pred     = ^(state_reg & poly_reg);
  assign accepted = bus.EN_I && !bus.LOAD_I && (poly_reg != '0);
  assign mismatch = bus.BIT_I ^ pred;
  assign err_hit  = accepted && (fsm == ST_LOCKED) && mismatch;

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      fsm       <= ST_FILL;
      poly_reg  <= '0;
      state_reg <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      err_cnt   <= '0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= err_hit;

      // Clear wins over the old count, but an error on the same edge still counts.
      if (bus.CLR_I) begin
        err_cnt <= {{(ERR_CNT_W-1){1'b0}}, err_hit};
      end else if (err_hit && (err_cnt != '1)) begin
        err_cnt <= err_cnt + 1'b1;
      end

      if (bus.LOAD_I) begin
        poly_reg  <= bus.POLY_I;
        fsm       <= ST_FILL;
        fill_cnt  <= '0;
        match_cnt <= '0;
        win_cnt   <= '0;
        win_err   <= '0;
        locked_q  <= 1'b0;
      end else if (accepted) begin
        case (fsm)
          ST_FILL: begin
            state_reg <= {state_reg[W-2:0], bus.BIT_I};
            if (fill_cnt == FILL_LAST) begin
              fill_cnt  <= '0;
              match_cnt <= '0;
              fsm       <= ST_HUNT;
            end else begin
              fill_cnt <= fill_cnt + 1'b1;
            end
          end

          ST_HUNT: begin
            state_reg <= {state_reg[W-2:0], bus.BIT_I};
            if (!mismatch) begin
              if (match_cnt == MATCH_LAST) begin
                match_cnt <= '0;
                win_cnt   <= '0;
                win_err   <= '0;
                locked_q  <= 1'b1;
                fsm       <= ST_LOCKED;
              end else begin
                match_cnt <= match_cnt + 1'b1;
              end
            end else begin
              match_cnt <= '0;
            end
          end

          ST_LOCKED: begin
            // Free-run on our own prediction so a line error never corrupts
            // the local sequence.
            state_reg <= {state_reg[W-2:0], pred};
            if (mismatch && (win_err == WERR_LAST)) begin
              match_cnt <= '0;
              win_cnt   <= '0;
              win_err   <= '0;
              locked_q  <= 1'b0;
              fsm       <= ST_HUNT;
            end else if (win_cnt == WIN_LAST) begin
              win_cnt <= '0;
              win_err <= '0;
            end else begin
              win_cnt <= win_cnt + 1'b1;
              win_err <= win_err + {{(WERR_W-1){1'b0}}, mismatch};
            end
          end

          default: begin
            locked_q <= 1'b0;
            fsm      <= ST_FILL;
          end
        endcase
      end
    end
  end

  assign bus.LOCKED_O  = locked_q;
  assign bus.ERR_O     = err_q;
  assign bus.ERR_CNT_O = err_cnt;

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// tb/tb_lfsr_prbs_checker.sv - directed self-checking bench for lfsr_prbs_checker
module tb_lfsr_prbs_checker;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  lfsr_prbs_checker_if #(.W(8), .ERR_CNT_W(16)) bus  ();
  lfsr_prbs_checker_if #(.W(8), .ERR_CNT_W(4))  bus4 ();

  lfsr_prbs_checker #(
    .W(8), .LOCK_CNT(16), .LOSS_WIN(32), .LOSS_THR(4), .ERR_CNT_W(16)
  ) dut (
    .CLK_I   (clk),
    .RST_N_I (rst_n),
    .bus     (bus.slave)
  );

  lfsr_prbs_checker #(
    .W(8), .LOCK_CNT(16), .LOSS_WIN(32), .LOSS_THR(4), .ERR_CNT_W(4)
  ) dut4 (
    .CLK_I   (clk),
    .RST_N_I (rst_n),
    .bus     (bus4.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] g;
  logic [7:0] gpoly;
  logic       err_seen;
  logic       lock_seen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic load, input logic [7:0] poly, input logic en,
                       input logic b, input logic clr);
    bus.LOAD_I  = load;  bus4.LOAD_I  = load;
    bus.POLY_I  = poly;  bus4.POLY_I  = poly;
    bus.EN_I    = en;    bus4.EN_I    = en;
    bus.BIT_I   = b;     bus4.BIT_I   = b;
    bus.CLR_I   = clr;   bus4.CLR_I   = clr;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference generator: output bit is the feedback bit shifted in.
  task automatic send(input logic inv, input logic en, input logic clr);
    logic f;
    logic b;
    if (en) begin
      f = ^(g & gpoly);
      g = {g[6:0], f};
      b = f ^ inv;
    end else begin
      b = 1'($urandom_range(0, 1));
    end
    drive(1'b0, 8'h00, en, b, clr);
    tick();
    if (bus.ERR_O)    err_seen  = 1'b1;
    if (bus.LOCKED_O) lock_seen = 1'b1;
  endtask

  task automatic send_clean(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 1'b1, 1'b0);
  endtask

  task automatic load(input logic [7:0] p);
    drive(1'b1, p, 1'b1, 1'b1, 1'b0);
    tick();
    gpoly = p;
    g     = 8'h01;
  endtask

  int acc;
  int cyc;
  logic en_r;

  initial begin
    rst_n     = 1'b0;
    g         = 8'h01;
    gpoly     = 8'h00;
    err_seen  = 1'b0;
    lock_seen = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_locked", 32'(bus.LOCKED_O), 32'd0);
    chk("rst_err",    32'(bus.ERR_O),    32'd0);
    chk("rst_cnt",    32'(bus.ERR_CNT_O), 32'd0);
    rst_n = 1'b1;
    tick();

    // Clean lock: 8 fill + 16 hunt bits
    load(8'hB8);
    send_clean(23);
    chk("t2_prelock_23", 32'(bus.LOCKED_O), 32'd0);
    send_clean(1);
    chk("t2_lock_24", 32'(bus.LOCKED_O), 32'd1);
    err_seen = 1'b0;
    send_clean(1000);
    chk("t2_clean_cnt",   32'(bus.ERR_CNT_O), 32'd0);
    chk("t2_no_err",      32'(err_seen),      32'd0);
    chk("t2_still_lock",  32'(bus.LOCKED_O),  32'd1);

    // Single error, no propagation (locked bit index 1099)
    send_clean(99);
    send(1'b1, 1'b1, 1'b0);
    chk("t3_err_pulse", 32'(bus.ERR_O),     32'd1);
    chk("t3_cnt",       32'(bus.ERR_CNT_O), 32'd1);
    chk("t3_locked",    32'(bus.LOCKED_O),  32'd1);
    err_seen = 1'b0;
    send_clean(100);
    chk("t3_no_prop",   32'(err_seen),      32'd0);
    chk("t3_cnt_hold",  32'(bus.ERR_CNT_O), 32'd1);

    // 3 errors in a window (indices 1200..1202) keep lock
    for (int i = 0; i < 3; i++) send(1'b1, 1'b1, 1'b0);
    chk("t4_three_locked", 32'(bus.LOCKED_O),  32'd1);
    chk("t4_three_cnt",    32'(bus.ERR_CNT_O), 32'd4);
    send_clean(13);
    send(1'b0, 1'b0, 1'b1);
    chk("t4_clr", 32'(bus.ERR_CNT_O), 32'd0);
    // 4 errors at the start of window 1216..1247 drop lock
    for (int i = 0; i < 3; i++) send(1'b1, 1'b1, 1'b0);
    chk("t4_3rd_locked", 32'(bus.LOCKED_O), 32'd1);
    send(1'b1, 1'b1, 1'b0);
    chk("t4_loss",    32'(bus.LOCKED_O),  32'd0);
    chk("t4_err4",    32'(bus.ERR_O),     32'd1);
    chk("t4_cnt4",    32'(bus.ERR_CNT_O), 32'd4);
    send_clean(15);
    chk("t4_hunt15",  32'(bus.LOCKED_O),  32'd0);
    send_clean(1);
    chk("t4_relock",  32'(bus.LOCKED_O),  32'd1);

    // Random EN: lock point in accepted bits unchanged
    load(8'hB8);
    chk("t5_load_unlock", 32'(bus.LOCKED_O),  32'd0);
    chk("t5_cnt_kept",    32'(bus.ERR_CNT_O), 32'd4);
    acc = 0;
    cyc = 0;
    while (acc < 24 && cyc < 500) begin
      en_r = 1'($urandom_range(0, 1));
      send(1'b0, en_r, 1'b0);
      cyc++;
      if (en_r) acc++;
      if (en_r && acc == 23) chk("t5_prelock", 32'(bus.LOCKED_O), 32'd0);
    end
    chk("t5_acc_bound", 32'(acc), 32'd24);
    chk("t5_lock",      32'(bus.LOCKED_O), 32'd1);
    acc = 0;
    cyc = 0;
    err_seen = 1'b0;
    while (acc < 10 && cyc < 500) begin
      en_r = 1'($urandom_range(0, 1));
      send(1'b0, en_r, 1'b0);
      cyc++;
      if (en_r) acc++;
    end
    chk("t5_clean", 32'(err_seen), 32'd0);
    send(1'b1, 1'b1, 1'b0);
    chk("t5_err",     32'(bus.ERR_O),     32'd1);
    chk("t5_cnt",     32'(bus.ERR_CNT_O), 32'd5);
    send(1'b1, 1'b0, 1'b0);
    chk("t5_en0_err", 32'(bus.ERR_O),     32'd0);
    chk("t5_en0_cnt", 32'(bus.ERR_CNT_O), 32'd5);
    load(8'hB8);
    chk("t5_load_mid", 32'(bus.LOCKED_O),  32'd0);
    chk("t5_load_cnt", 32'(bus.ERR_CNT_O), 32'd5);

    // Saturation: 20 errors spaced 11 bits apart (max 3 per window)
    send_clean(24);
    chk("t6_lock", 32'(bus.LOCKED_O), 32'd1);
    for (int e = 0; e < 20; e++) begin
      send(1'b1, 1'b1, 1'b0);
      send_clean(10);
    end
    chk("t6_cnt16",   32'(bus.ERR_CNT_O),  32'd25);
    chk("t6_cnt4sat", 32'(bus4.ERR_CNT_O), 32'd15);
    chk("t6_locked",  32'(bus.LOCKED_O),   32'd1);
    send(1'b1, 1'b1, 1'b1);
    chk("t6_clr_err16", 32'(bus.ERR_CNT_O),  32'd1);
    chk("t6_clr_err4",  32'(bus4.ERR_CNT_O), 32'd1);
    chk("t6_clr_pulse", 32'(bus.ERR_O),      32'd1);

    // POLY=0: nothing accepted, never locks
    load(8'h00);
    gpoly = 8'hB8;
    lock_seen = 1'b0;
    send_clean(60);
    chk("t6_poly0_lock", 32'(lock_seen),     32'd0);
    chk("t6_poly0_cnt",  32'(bus.ERR_CNT_O), 32'd1);

    // Async reset mid-stream while locked and ERR_O high
    load(8'hB8);
    send_clean(24);
    chk("t1_locked", 32'(bus.LOCKED_O), 32'd1);
    send(1'b1, 1'b1, 1'b0);
    chk("t1_err_pre", 32'(bus.ERR_O), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_rst_locked", 32'(bus.LOCKED_O),   32'd0);
    chk("t1_rst_err",    32'(bus.ERR_O),      32'd0);
    chk("t1_rst_cnt",    32'(bus.ERR_CNT_O),  32'd0);
    chk("t1_rst_cnt4",   32'(bus4.ERR_CNT_O), 32'd0);
    #3 rst_n = 1'b1;
    lock_seen = 1'b0;
    send_clean(30);
    chk("t1_fill_nopoly", 32'(lock_seen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
